ram_arbiter: RTL and testbench

//  Shares the single-port 32Kx16 ram between two requesters (m0, m1) via round-robin arbitration.

---
 rtl/ram_arbiter_pkg.sv | 27 ++
 rtl/ram_arbiter_if.sv | 25 ++
 rtl/ram_arbiter_rr_arb2.sv | 38 +++
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default geometry for the two-requester ram arbiter.
package ram_arb_pkg;

   localparam int RAM_ADDR_W = 15;
   localparam int RAM_DATA_W = 16;

   typedef enum logic {
      REQ_M0 = 1'b0,
      REQ_M1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic                  we;
      logic [RAM_ADDR_W-1:0] addr;
      logic [RAM_DATA_W-1:0] wdata;
   } ram_req_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

   function automatic req_id_t gnt_to_id(input logic [1:0] gnt);
      return gnt[1] ? REQ_M1 : REQ_M0;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's view of the arbiter: valid/ready request channel plus read-response channel.
interface ram_arbiter_if #(
   parameter int ADDR_W = ram_arb_pkg::RAM_ADDR_W,
   parameter int DATA_W = ram_arb_pkg::RAM_DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on contention, grants the requester not granted last time.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

   req_id_t    r_last_gnt;
   logic [1:0] w_gnt;

   always_comb begin
      // NOTE: default assignment first keeps every path covered, so no latch is inferred.
      w_gnt = 2'b00;
      unique case (i_req)
         2'b01:   w_gnt = 2'b01;
         2'b10:   w_gnt = 2'b10;
         2'b11:   w_gnt = (r_last_gnt == REQ_M0) ? 2'b10 : 2'b01;
         default: w_gnt = 2'b00;
      endcase
   end

   // Reset value of "last granted = m1" makes m0 the preferred requester after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all flop state, so every flop sees pre-edge values.
      if (!rst_n) begin
         r_last_gnt <= REQ_M1;
      end else if (i_accept) begin
         r_last_gnt <= gnt_to_id(w_gnt);
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port ram between two requesters: request mux, read-tag pipeline, responses.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_arbiter_if.slave      m0,
   ram_arbiter_if.slave      m1,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_data_out
);

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_accept;
   req_id_t           w_gnt_id;
   ram_req_t          w_req_m0;
   ram_req_t          w_req_m1;
   ram_req_t          w_sel;
   rd_tag_t           w_tag_in;
   rd_tag_t           w_tag_out;

   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_data;
   rd_tag_t           r_tag [RD_LAT];
   logic              r_rsp_valid_m0;
   logic              r_rsp_valid_m1;
   logic [DATA_W-1:0] r_rsp_rdata_m0;
   logic [DATA_W-1:0] r_rsp_rdata_m1;

   // Requests are masked during reset so no ready (and no ram access) can leak out.
   assign w_req = {m1.req_valid, m0.req_valid} & {2{rst_n}};

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (w_req),
      .i_accept (w_accept),
      .o_gnt    (w_gnt)
   );

   assign w_accept     = |w_gnt;
   assign w_gnt_id     = gnt_to_id(w_gnt);
   assign m0.req_ready = w_gnt[0];
   assign m1.req_ready = w_gnt[1];

   assign w_req_m0 = '{we: m0.req_we, addr: m0.req_addr, wdata: m0.req_wdata};
   assign w_req_m1 = '{we: m1.req_we, addr: m1.req_addr, wdata: m1.req_wdata};
   assign w_sel    = (w_gnt_id == REQ_M1) ? w_req_m1 : w_req_m0;

   // The ram sees the granted request live; when idle, address/data park on the last access.
   assign ram_address      = w_accept ? w_sel.addr  : r_ram_addr;
   assign ram_data         = w_accept ? w_sel.wdata : r_ram_data;
   assign ram_write_enable = w_accept & w_sel.we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_addr <= '0;
         r_ram_data <= '0;
      end else if (w_accept) begin
         r_ram_addr <= w_sel.addr;
         r_ram_data <= w_sel.wdata;
      end
   end

   assign w_tag_in = '{valid: w_accept & ~w_sel.we, id: w_gnt_id};

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the tag pipeline is plain flops and is reset, so reads in flight die with reset.
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= w_tag_in;
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // A tag leaves the pipe in the same cycle its data is on ram_data_out.
   assign w_tag_out = r_tag[RD_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid_m0 <= 1'b0;
         r_rsp_valid_m1 <= 1'b0;
         r_rsp_rdata_m0 <= '0;
         r_rsp_rdata_m1 <= '0;
      end else begin
         r_rsp_valid_m0 <= w_tag_out.valid & (w_tag_out.id == REQ_M0);
         r_rsp_valid_m1 <= w_tag_out.valid & (w_tag_out.id == REQ_M1);
         if (w_tag_out.valid && w_tag_out.id == REQ_M0) begin
            r_rsp_rdata_m0 <= ram_data_out;
         end
         if (w_tag_out.valid && w_tag_out.id == REQ_M1) begin
            r_rsp_rdata_m1 <= ram_data_out;
         end
      end
   end

   assign m0.rsp_valid = r_rsp_valid_m0;
   assign m1.rsp_valid = r_rsp_valid_m1;
   assign m0.rsp_rdata = r_rsp_rdata_m0;
   assign m1.rsp_rdata = r_rsp_rdata_m1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural ram, acceptance monitor with per-port response scoreboards.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   localparam int RD_LAT = 1;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [14:0] ram_address;
   logic [15:0] ram_data;
   logic        ram_write_enable;
   logic [15:0] ram_data_out;

   ram_arbiter_if m0 ();
   ram_arbiter_if m1 ();

   ram_arbiter #(.RD_LAT(RD_LAT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .m0               (m0),
      .m1               (m1),
      .ram_address      (ram_address),
      .ram_data         (ram_data),
      .ram_write_enable (ram_write_enable),
      .ram_data_out     (ram_data_out)
   );

   always #5 clk = ~clk;

   // Behavioural single-port ram: write commits on the edge, read data RD_LAT edges later.
   logic [15:0] ram_mem  [32768];
   logic [15:0] ram_pipe [RD_LAT];
   always @(posedge clk) begin
      if (ram_write_enable) ram_mem[ram_address] <= ram_data;
      ram_pipe[0] <= ram_mem[ram_address];
      for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
   end
   assign ram_data_out = ram_pipe[RD_LAT-1];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [15:0] ref_mem [32768];
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        rsp_log0[$];
   exp_t        rsp_log1[$];
   int          grant_log[$];

   // Runs forked from the main initial block; samples everything on the falling edge.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q0.delete();
            q1.delete();
         end else begin
            if (m0.rsp_valid) begin
               rsp_log0.push_back('{m0.rsp_rdata, cyc});
               n_cmp++;
               if (q0.size() == 0) begin
                  n_err++;
                  $display("FAIL m0_unexpected_rsp: got rsp_valid data %h, want no response", m0.rsp_rdata);
               end else begin
                  e = q0.pop_front();
                  if (m0.rsp_rdata !== e.data || cyc != e.due) begin
                     n_err++;
                     $display("FAIL m0_rsp: got %h at cycle %0d, want %h at cycle %0d", m0.rsp_rdata, cyc, e.data, e.due);
                  end
               end
            end else if (q0.size() != 0 && q0[0].due < cyc) begin
               n_cmp++;
               n_err++;
               $display("FAIL m0_missing_rsp: got none by cycle %0d, want %h at cycle %0d", cyc, q0[0].data, q0[0].due);
               void'(q0.pop_front());
            end
            if (m1.rsp_valid) begin
               rsp_log1.push_back('{m1.rsp_rdata, cyc});
               n_cmp++;
               if (q1.size() == 0) begin
                  n_err++;
                  $display("FAIL m1_unexpected_rsp: got rsp_valid data %h, want no response", m1.rsp_rdata);
               end else begin
                  e = q1.pop_front();
                  if (m1.rsp_rdata !== e.data || cyc != e.due) begin
                     n_err++;
                     $display("FAIL m1_rsp: got %h at cycle %0d, want %h at cycle %0d", m1.rsp_rdata, cyc, e.data, e.due);
                  end
               end
            end else if (q1.size() != 0 && q1[0].due < cyc) begin
               n_cmp++;
               n_err++;
               $display("FAIL m1_missing_rsp: got none by cycle %0d, want %h at cycle %0d", cyc, q1[0].data, q1[0].due);
               void'(q1.pop_front());
            end
            if (m0.req_valid && m0.req_ready) begin
               grant_log.push_back(0);
               if (m0.req_we) ref_mem[m0.req_addr] = m0.req_wdata;
               else q0.push_back('{ref_mem[m0.req_addr], cyc + RD_LAT + 1});
            end
            if (m1.req_valid && m1.req_ready) begin
               grant_log.push_back(1);
               if (m1.req_we) ref_mem[m1.req_addr] = m1.req_wdata;
               else q1.push_back('{ref_mem[m1.req_addr], cyc + RD_LAT + 1});
            end
         end
         cyc++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit id, input logic v, input logic we, input logic [14:0] a, input logic [15:0] d);
      if (id) begin
         m1.req_valid = v; m1.req_we = we; m1.req_addr = a; m1.req_wdata = d;
      end else begin
         m0.req_valid = v; m0.req_we = we; m0.req_addr = a; m0.req_wdata = d;
      end
   endtask

   // Holds the request until accepted; returns just after the accepting edge.
   task automatic send(input bit id, input logic we, input logic [14:0] a, input logic [15:0] d);
      bit got = 1'b0;
      drive(id, 1'b1, we, a, d);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = id ? m1.req_ready : m0.req_ready;
         step();
      end
      if (id) m1.req_valid = 1'b0; else m0.req_valid = 1'b0;
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: port %0d got no ready in 20 cycles, want ready", id);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) step();
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d/%0d responses outstanding, want 0/0", q0.size(), q1.size());
      end
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if (m0.req_ready !== 1'b0 || m1.req_ready !== 1'b0 || m0.rsp_valid !== 1'b0 ||
          m1.rsp_valid !== 1'b0 || m0.rsp_rdata !== 16'h0 || m1.rsp_rdata !== 16'h0 ||
          ram_write_enable !== 1'b0 || ram_address !== 15'h0 || ram_data !== 16'h0) begin
         n_err++;
         $display("FAIL %s: got rdy %b%b rv %b%b rd %h/%h we %b addr %h data %h, want all zero", tag,
                  m0.req_ready, m1.req_ready, m0.rsp_valid, m1.rsp_valid, m0.rsp_rdata,
                  m1.rsp_rdata, ram_write_enable, ram_address, ram_data);
      end
   endtask

   task automatic test_reset();
      drive(0, 1'b1, 1'b0, 15'h0005, 16'h0);
      drive(1, 1'b1, 1'b1, 15'h0006, 16'hFFFF);
      step();
      step();
      check_reset_outputs("reset_state");
      drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 15'h0, 16'h0);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      int  edges = 1;
      bit  seen_m0 = 1'b0;
      send(0, 1'b1, 15'h1A3B, 16'hAAAA);
      send(1, 1'b0, 15'h1A3B, 16'h0);
      while (!m1.rsp_valid && edges < 10) begin
         step();
         edges++;
         if (m0.rsp_valid) seen_m0 = 1'b1;
      end
      n_cmp++;
      if (edges != RD_LAT + 1) begin
         n_err++;
         $display("FAIL wr_rd_latency: got %0d edges, want %0d", edges, RD_LAT + 1);
      end
      n_cmp++;
      if (m1.rsp_rdata !== 16'hAAAA) begin
         n_err++;
         $display("FAIL wr_rd_data: got %h, want aaaa", m1.rsp_rdata);
      end
      n_cmp++;
      if (seen_m0 || m0.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wr_rd_m0_quiet: got m0 rsp_valid, want none");
      end
      wait_drain();
   endtask

   task automatic test_fairness();
      int base, b0, b1, c0 = 0, c1 = 0;
      bit a0, a1;
      send(0, 1'b1, 15'h0010, 16'hC0DE);
      send(1, 1'b1, 15'h0020, 16'hBEEF);
      base = grant_log.size();
      b0 = rsp_log0.size();
      b1 = rsp_log1.size();
      drive(0, 1'b1, 1'b0, 15'h0010, 16'h0);
      drive(1, 1'b1, 1'b0, 15'h0020, 16'h0);
      for (int i = 0; i < 20 && (c0 < 3 || c1 < 3); i++) begin
         @(negedge clk);
         a0 = m0.req_ready;
         a1 = m1.req_ready;
         step();
         if (a0) c0++;
         if (a1) c1++;
         if (c0 >= 3) m0.req_valid = 1'b0;
         if (c1 >= 3) m1.req_valid = 1'b0;
      end
      m0.req_valid = 1'b0;
      m1.req_valid = 1'b0;
      wait_drain();
      n_cmp++;
      if (grant_log.size() - base != 6) begin
         n_err++;
         $display("FAIL fair_count: got %0d grants, want 6", grant_log.size() - base);
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (grant_log[base+i] != i % 2) begin
               n_err++;
               $display("FAIL fair_order[%0d]: got m%0d, want m%0d", i, grant_log[base+i], i % 2);
            end
         end
      end
      n_cmp++;
      if (rsp_log0.size() - b0 != 3 || rsp_log1.size() - b1 != 3) begin
         n_err++;
         $display("FAIL fair_rsp_count: got %0d/%0d, want 3/3", rsp_log0.size() - b0, rsp_log1.size() - b1);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] tbl [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      int base;
      for (int i = 0; i < 4; i++) send(0, 1'b1, 15'(i), tbl[i]);
      base = rsp_log0.size();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 1'b0, 15'(i), 16'h0);
         @(negedge clk);
         n_cmp++;
         if (m0.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready[%0d]: got %b, want 1", i, m0.req_ready);
         end
         step();
      end
      m0.req_valid = 1'b0;
      wait_drain();
      n_cmp++;
      if (rsp_log0.size() - base != 4) begin
         n_err++;
         $display("FAIL b2b_count: got %0d responses, want 4", rsp_log0.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rsp_log0[base+i].data !== tbl[i] || rsp_log0[base+i].due != rsp_log0[base].due + i) begin
               n_err++;
               $display("FAIL b2b_rsp[%0d]: got %h at cycle %0d, want %h at cycle %0d", i,
                        rsp_log0[base+i].data, rsp_log0[base+i].due, tbl[i], rsp_log0[base].due + i);
            end
         end
      end
   endtask

   task automatic test_raw();
      send(1, 1'b1, 15'h7FFF, 16'h5A5A);
      send(1, 1'b0, 15'h7FFF, 16'h0);
      wait_drain();
      n_cmp++;
      if (m1.rsp_rdata !== 16'h5A5A) begin
         n_err++;
         $display("FAIL raw_data: got %h, want 5a5a", m1.rsp_rdata);
      end
      n_cmp++;
      if (ram_address !== 15'h7FFF || ram_data !== 16'h0 || ram_write_enable !== 1'b0) begin
         n_err++;
         $display("FAIL idle_hold: got addr %h data %h we %b, want 7fff 0000 0", ram_address, ram_data, ram_write_enable);
      end
   endtask

   task automatic test_reset_mid();
      send(0, 1'b0, 15'h0001, 16'h0);
      rst_n = 1'b0;
      drive(0, 1'b1, 1'b0, 15'h0001, 16'h0);
      drive(1, 1'b1, 1'b0, 15'h0002, 16'h0);
      #1;
      check_reset_outputs("reset_mid_state");
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (m0.req_ready !== 1'b1 || m1.req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_first_grant: got ready m0=%b m1=%b, want m0=1 m1=0", m0.req_ready, m1.req_ready);
      end
      step();
      m0.req_valid = 1'b0;
      m1.req_valid = 1'b0;
      wait_drain();
      n_cmp++;
      if (m0.rsp_rdata !== 16'h2222) begin
         n_err++;
         $display("FAIL reset_mid_after: got %h, want 2222", m0.rsp_rdata);
      end
   endtask

   task automatic test_hold();
      send(1, 1'b1, 15'h0200, 16'h0F0F);
      drive(0, 1'b1, 1'b0, 15'h0200, 16'h0);
      drive(1, 1'b1, 1'b1, 15'h0300, 16'h7777);
      @(negedge clk);
      n_cmp++;
      if (m0.req_ready !== 1'b1 || m1.req_ready !== 1'b0 || ram_address !== 15'h0200 || ram_write_enable !== 1'b0) begin
         n_err++;
         $display("FAIL hold_first: got rdy %b%b addr %h we %b, want 10 0200 0",
                  m0.req_ready, m1.req_ready, ram_address, ram_write_enable);
      end
      step();
      m0.req_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (m1.req_ready !== 1'b1 || ram_address !== 15'h0300 || ram_data !== 16'h7777 || ram_write_enable !== 1'b1) begin
         n_err++;
         $display("FAIL hold_second: got rdy %b addr %h data %h we %b, want 1 0300 7777 1",
                  m1.req_ready, ram_address, ram_data, ram_write_enable);
      end
      step();
      m1.req_valid = 1'b0;
      send(1, 1'b0, 15'h0300, 16'h0);
      wait_drain();
      n_cmp++;
      if (m0.rsp_rdata !== 16'h0F0F || m1.rsp_rdata !== 16'h7777) begin
         n_err++;
         $display("FAIL hold_data: got %h/%h, want 0f0f/7777", m0.rsp_rdata, m1.rsp_rdata);
      end
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 15'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 15'h0, 16'h0);
      fork
         monitor();
      join_none
      test_reset();
      test_write_read();
      test_fairness();
      test_back_to_back();
      test_raw();
      test_reset_mid();
      test_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time limit, want bench to finish");
      $fatal(1, "watchdog expired");
   end

endmodule
